deshift_reg: RTL and testbench

DESHIFT_REG -- requirements
Module: deshift_reg

---
 rtl/deshift_reg_pkg.sv | 12 +
 rtl/deshift_reg.sv | 110 +++++++++++
 tb/tb_deshift_reg.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/deshift_reg_pkg.sv
// Shared constants and state type for the serial-to-parallel frame deserializer.
package deshift_reg_pkg;

    localparam int DEF_WORD_SIZE = 4;
    localparam int DEF_NUM_WORDS = 16;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/deshift_reg.sv
// Deserializer: collects WORD_SIZE-bit words into a NUM_WORDS-word frame, first word in the MSB slot,
// with early-close flush and a same-cycle drain/accept path.
module deshift_reg
    import deshift_reg_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               in_valid,
    input  logic [WORD_SIZE-1:0]               in_data,
    output logic                               in_ready,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WORD_SIZE*NUM_WORDS-1:0]     out_data,
    output logic [$clog2(NUM_WORDS+1)-1:0]     out_count
);

    localparam int CW = $clog2(NUM_WORDS + 1);

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d, cnt_inc;
    logic [CW-1:0]        count_q, count_d;
    logic [WORD_SIZE-1:0] frame_q [NUM_WORDS];
    logic                 word_xfer, frame_xfer;
    logic                 wr_en, clr;
    logic [CW-1:0]        wr_idx;

    assign in_ready   = (state == FILL) || out_ready;
    assign out_valid  = (state == FULL);
    assign word_xfer  = in_valid && in_ready;
    assign frame_xfer = out_valid && out_ready;
    assign cnt_inc    = cnt + 1'b1;
    assign out_count  = count_q;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = cnt;
        clr     = 1'b0;
        case (state)
            FILL: begin
                if (word_xfer) begin
                    wr_en = 1'b1;
                    if (cnt_inc == CW'(NUM_WORDS) || flush) begin
                        state_d = FULL;
                        count_d = cnt_inc;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (flush && cnt != '0) begin
                    state_d = FULL;
                    count_d = cnt;
                    cnt_d   = '0;
                end
            end
            FULL: begin
                // Drain clears the buffer; a word accepted on the same edge lands in slot 0 instead.
                if (frame_xfer) begin
                    state_d = FILL;
                    clr     = 1'b1;
                    count_d = '0;
                    wr_idx  = '0;
                    if (word_xfer) begin
                        wr_en = 1'b1;
                        cnt_d = CW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= FILL;
            cnt     <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                if (wr_en && wr_idx == CW'(i)) begin
                    frame_q[i] <= in_data;
                end else if (clr) begin
                    frame_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            out_data[WORD_SIZE*(NUM_WORDS-k)-1 -: WORD_SIZE] = frame_q[k];
        end
    end

endmodule

// File: tb/tb_deshift_reg.sv
// Self-checking bench for deshift_reg: directed frame/flush/reset cases plus a serializer round trip.
module tb_deshift_reg;

    localparam int W  = 4;
    localparam int N  = 16;
    localparam int CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [W*N-1:0] out_data;
    logic [CW-1:0]  out_count;

    typedef struct packed {
        logic [63:0]   data;
        logic [CW-1:0] count;
    } frame_t;

    frame_t sb[$];
    frame_t mon_f;
    int tests = 0;
    int fails = 0;

    deshift_reg #(.WORD_SIZE(W), .NUM_WORDS(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic frame_t mk(input logic [63:0] d, input int c);
        frame_t f;
        f.data  = d;
        f.count = CW'(c);
        return f;
    endfunction

    // Frame handshake seen mid-cycle: the transfer happens on the coming edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_f = sb.pop_front();
                check("frame_data", out_data, mon_f.data);
                check("frame_count", 64'(out_count), 64'(mon_f.count));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic send_random_frame(output logic [63:0] exp);
        logic [W-1:0] d;
        exp = '0;
        for (int i = 0; i < N; i++) begin
            d = W'($urandom);
            exp[63-4*i -: 4] = d;
            put(d);
        end
    endtask

    initial begin
        logic [63:0] exp;
        logic [63:0] cur;
        logic [W-1:0] d;
        logic accepted;
        int idx;
        int fr;
        int cycles;

        // Reset with every other input active: reset must win.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'hF;
        flush     = 1'b1;
        out_ready = 1'b1;
        repeat (2) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        reset_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        step();

        // Full frame 1..F,0
        for (int i = 0; i < N; i++) begin
            put(W'((i + 1) % 16));
            if (i == N - 2) check("full_not_early", 64'(out_valid), 64'd0);
        end
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_data", out_data, 64'h123456789ABCDEF0);
        check("full_count", 64'(out_count), 64'd16);
        check("full_in_ready", 64'(in_ready), 64'd0);
        sb.push_back(mk(64'h123456789ABCDEF0, 16));

        // Back-pressure with flush held (ignored in FULL)
        in_valid = 1'b1; in_data = 4'h5; flush = 1'b1;
        repeat (10) step();
        check("bp_data", out_data, 64'h123456789ABCDEF0);
        check("bp_count", 64'(out_count), 64'd16);
        check("bp_valid", 64'(out_valid), 64'd1);
        flush = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        check("bp_drain_valid", 64'(out_valid), 64'd0);
        check("bp_new_slot0", out_data, 64'h5000_0000_0000_0000);
        exp = 64'h5000_0000_0000_0000;
        for (int i = 1; i < N; i++) begin
            d = W'($urandom);
            exp[63-4*i -: 4] = d;
            put(d);
        end
        check("bp_frame2_valid", 64'(out_valid), 64'd1);
        sb.push_back(mk(exp, 16));
        drain();
        check("drain_clears", out_data, 64'd0);

        // Flush after two words
        put(4'hA);
        put(4'hB);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd1);
        check("flush_count", 64'(out_count), 64'd2);
        check("flush_data", out_data, 64'hAB00_0000_0000_0000);
        sb.push_back(mk(64'hAB00_0000_0000_0000, 2));
        drain();

        // Flush together with a word
        put(4'h1); put(4'h2); put(4'h3);
        flush = 1'b1;
        put(4'h4);
        flush = 1'b0;
        check("flushw_count", 64'(out_count), 64'd4);
        check("flushw_data", out_data, 64'h1234_0000_0000_0000);
        sb.push_back(mk(64'h1234_0000_0000_0000, 4));
        drain();

        // Empty flush
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("eflush_valid", 64'(out_valid), 64'd0);
        check("eflush_count", 64'(out_count), 64'd0);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) put(W'($urandom));
        reset_n = 1'b0; in_valid = 1'b1; in_data = 4'h7;
        step();
        reset_n = 1'b1; in_valid = 1'b0;
        check("midrst_data", out_data, 64'd0);
        send_random_frame(exp);
        check("midrst_count", 64'(out_count), 64'd16);
        check("midrst_data2", out_data, exp);
        sb.push_back(mk(exp, 16));
        drain();

        // Reset while FULL discards the frame
        send_random_frame(exp);
        check("fullrst_pre", 64'(out_valid), 64'd1);
        reset_n = 1'b0; out_ready = 1'b1;
        step();
        reset_n = 1'b1; out_ready = 1'b0;
        check("fullrst_valid", 64'(out_valid), 64'd0);
        check("fullrst_data", out_data, 64'd0);

        // Round trip: serializer model feeding random frames with random gaps/back-pressure
        fr = 0; idx = 0; cycles = 0;
        cur = {$urandom, $urandom};
        sb.push_back(mk(cur, 16));
        while (fr < 1000 && cycles < 60000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            in_data   = cur[63-4*idx -: 4];
            #1;
            accepted = in_valid && in_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (accepted) begin
                idx++;
                if (idx == N) begin
                    idx = 0;
                    fr++;
                    if (fr < 1000) begin
                        cur = {$urandom, $urandom};
                        sb.push_back(mk(cur, 16));
                    end
                end
            end
        end
        check("rt_frames_sent", 64'(fr), 64'd1000);
        in_valid = 1'b0; out_ready = 1'b1;
        cycles = 0;
        while (sb.size() != 0 && cycles < 50) begin
            step();
            cycles++;
        end
        out_ready = 1'b0;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
